regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the RegisterFile's single write port (WriteRegister, WriteData, RegWrite) between two requesters:
  - Req0: pipeline writeback stage.
  - Req1: multi-cycle unit, e.g. multiply/divide or a long-latency load.
- Keeps a pending-write scoreboard for Req1 destinations and raises Stall when a decode-stage read source is still pending.
- Sits between the WB stage, the multi-cycle unit and the RegisterFile.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register index width (2^ADDR_W registers).
- FIXED_PRIORITY, 0: 0 = round-robin on conflict; 1 = Req0 always wins.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- Req0Valid  in  1  Req0 write request.
- Req0Reg  in  ADDR_W  Req0 destination register.
- Req0Data  in  DATA_W  Req0 write data.
- Req0Ready  out  1  Req0 accepted this cycle.
- Req1Valid  in  1  Req1 write request.
- Req1Reg  in  ADDR_W  Req1 destination register.
- Req1Data  in  DATA_W  Req1 write data.
- Req1Ready  out  1  Req1 accepted this cycle.
- Reserve  in  1  Req1 dispatch: mark ReserveReg pending.
- ReserveReg  in  ADDR_W  register to reserve.
- ReadRegister1  in  ADDR_W  decode source 1.
- ReadRegister2  in  ADDR_W  decode source 2.
- Stall  out  1  a source register has a pending write.
- WriteRegister  out  ADDR_W  to RegisterFile.
- WriteData  out  DATA_W  to RegisterFile.
- RegWrite  out  1  to RegisterFile.
- Pending  out  2^ADDR_W  scoreboard bit vector (debug/verification).

Behaviour:
- Reset:
  - Reset is sampled only on the rising Clk edge.
  - While Reset=0 at an edge, state becomes WriteRegister=0, WriteData=0, RegWrite=0, Pending=0, LastGrant=1 (so Req0 wins the first conflict).
  - Req0Ready and Req1Ready are forced to 0 whenever Reset=0.
  - Reset in the middle of an operation drops any in-flight output write and clears all reservations.
- Handshake (valid/ready):
  - A transfer occurs on an edge where Valid=1 and Ready=1.
  - Ready is combinational from both Valid inputs and LastGrant only; it never depends on either Ready.
  - A requester holds Reg and Data stable while Valid=1 and Ready=0.
  - At most one Ready is high per cycle.
- Arbitration:
  - Only one valid: that requester gets Ready=1.
  - Both valid, FIXED_PRIORITY=1: Req0 wins.
  - Both valid, FIXED_PRIORITY=0: the requester that did not win the last conflict wins. LastGrant updates only on conflict cycles.
  - The losing requester waits. Under round-robin, no requester waits more than 1 conflict cycle.
- Output latency:
  - A transfer accepted at edge N drives WriteRegister/WriteData/RegWrite=1 during cycle N+1.
  - The RegisterFile commits it at edge N+1.
  - With no transfer at edge N, RegWrite=0 in cycle N+1. WriteRegister and WriteData hold their previous values.
- Register 0:
  - A transfer with Reg=0 is accepted (Ready=1) but produces RegWrite=0.
  - Reserve with ReserveReg=0 is ignored.
  - Index 0 never contributes to Stall; Pending[0] is always 0.
- Scoreboard:
  - Reserve=1 sets Pending[ReserveReg] at the edge.
  - A Req1 transfer clears Pending[Req1Reg] at its accept edge.
  - Set and clear of the same register on the same edge: set wins, because it is a new reservation.
  - Reserving an already-pending register leaves it set.
  - A Req0 transfer never touches Pending.
- Stall:
  - Combinational: Stall = (ReadRegister1!=0 & Pending[ReadRegister1]) | (ReadRegister2!=0 & Pending[ReadRegister2]).
  - Stall deasserts in the cycle after the clearing edge, i.e. the same cycle the registered write is presented.
  - The decode stage relies on the RegisterFile write-then-read behaviour for that cycle.
- Estimated 150–250 lines of RTL.

Test Plan:
- Reset: hold Reset=0 for 2 cycles with both Valid=1 -> Ready0=Ready1=0, RegWrite=0, Pending=0, Stall=0. Release -> the first conflict grants Req0.
- Single requester: Req0Valid=1, Req0Reg=8, Req0Data=0x11 for 1 cycle -> Req0Ready=1 at that edge; the next cycle shows WriteRegister=8, WriteData=0x11, RegWrite=1; the cycle after shows RegWrite=0.
- Round-robin conflict (FIXED_PRIORITY=0): both valid for 4 cycles (R0: reg 9/0xA, R1: reg 10/0xB, each held until accepted, then new data) -> grants R0, R1, R0, R1, and the output sequence alternates registers 9, 10, 9, 10. Repeat with FIXED_PRIORITY=1 -> R0 wins every conflict.
- Scoreboard:
  - Reserve reg 16; next cycle ReadRegister1=16 -> Stall=1.
  - Req1 writes reg 16 = 0x1234 -> Stall stays 1 through the accept edge, then 0. Pending[16]=0 and WriteRegister=16, WriteData=0x1234, RegWrite=1 in that same cycle.
- Simultaneous set/clear: Pending[17]=1; Req1 transfer to 17 with Reserve=1, ReserveReg=17 at the same edge -> Pending[17] remains 1 and Stall persists for ReadRegister2=17.
- Register 0 and mid-op reset:
  - Req0 writes reg 0 = 0xFF -> Ready=1, RegWrite stays 0.
  - Reserve reg 0 -> Pending unchanged.
  - With Pending[20]=1 and a transfer just accepted, assert Reset=0 -> next cycle RegWrite=0, Pending=0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter
//  Description : Shares the register file's single write port between the
//                writeback stage (Req0) and a multi-cycle unit (Req1).
//                Tracks pending Req1 destinations and stalls decode when a
//                source register still awaits its write.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 5,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Req0Valid,
    input  logic [ADDR_W-1:0]        Req0Reg,
    input  logic [DATA_W-1:0]        Req0Data,
    output logic                     Req0Ready,
    input  logic                     Req1Valid,
    input  logic [ADDR_W-1:0]        Req1Reg,
    input  logic [DATA_W-1:0]        Req1Data,
    output logic                     Req1Ready,
    input  logic                     Reserve,
    input  logic [ADDR_W-1:0]        ReserveReg,
    input  logic [ADDR_W-1:0]        ReadRegister1,
    input  logic [ADDR_W-1:0]        ReadRegister2,
    output logic                     Stall,
    output logic [ADDR_W-1:0]        WriteRegister,
    output logic [DATA_W-1:0]        WriteData,
    output logic                     RegWrite,
    output logic [(1<<ADDR_W)-1:0]   Pending
);

    localparam int c_NREG = 1 << ADDR_W;

    // r_last_grant = 1 means Req1 won the most recent conflict, so Req0 wins next
    logic                 r_last_grant;
    logic [ADDR_W-1:0]    r_wreg;
    logic [DATA_W-1:0]    r_wdata;
    logic                 r_wen;
    logic [c_NREG-1:0]    r_pending;

    logic                 w_conflict;
    logic                 w_pick0;
    logic                 w_grant0;
    logic                 w_grant1;
    logic [c_NREG-1:0]    w_pending_nxt;

    assign w_conflict = Req0Valid && Req1Valid;
    assign w_pick0    = (FIXED_PRIORITY != 0) || r_last_grant;
    // Grants depend only on the valids, the conflict history and reset
    assign w_grant0   = Reset && Req0Valid && (!Req1Valid || w_pick0);
    assign w_grant1   = Reset && Req1Valid && !(Req0Valid && w_pick0);

    assign Req0Ready     = w_grant0;
    assign Req1Ready     = w_grant1;
    assign WriteRegister = r_wreg;
    assign WriteData     = r_wdata;
    assign RegWrite      = r_wen;
    assign Pending       = r_pending;

    // Index 0 is never reported as a hazard
    assign Stall = ((ReadRegister1 != '0) && r_pending[ReadRegister1]) ||
                   ((ReadRegister2 != '0) && r_pending[ReadRegister2]);

    // Next scoreboard: a new reservation beats a same-edge clear; bit 0 stays 0
    always_comb begin
        w_pending_nxt = '0;
        for (int i = 1; i < c_NREG; i++) begin
            w_pending_nxt[i] = (Reserve && (ReserveReg == ADDR_W'(i))) ||
                               (r_pending[i] && !(w_grant1 && (Req1Reg == ADDR_W'(i))));
        end
    end

    // Register the granted write, conflict history and scoreboard
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_wreg       <= '0;
            r_wdata      <= '0;
            r_wen        <= 1'b0;
            r_pending    <= '0;
            r_last_grant <= 1'b1;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_conflict) begin
                r_last_grant <= w_grant1;
            end
            if (w_grant0) begin
                r_wen <= (Req0Reg != '0);
                if (Req0Reg != '0) begin
                    r_wreg  <= Req0Reg;
                    r_wdata <= Req0Data;
                end
            end else if (w_grant1) begin
                r_wen <= (Req1Reg != '0);
                if (Req1Reg != '0) begin
                    r_wreg  <= Req1Reg;
                    r_wdata <= Req1Data;
                end
            end else begin
                r_wen <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_write_arbiter
//  Description : Scoreboard bench for regfile_write_arbiter (round-robin and
//                fixed-priority instances driven from the same stimulus).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Req0Valid, Req1Valid, Reserve;
    logic [4:0]  Req0Reg, Req1Reg, ReserveReg, ReadRegister1, ReadRegister2;
    logic [31:0] Req0Data, Req1Data;

    logic        Req0Ready, Req1Ready, Stall, RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [31:0] Pending;

    logic        fp_Req0Ready, fp_Req1Ready, fp_Stall, fp_RegWrite;
    logic [4:0]  fp_WriteRegister;
    logic [31:0] fp_WriteData;
    logic [31:0] fp_Pending;

    int   n_checks = 0;
    int   n_fail   = 0;
    wr_t  exp_q[$];
    logic [31:0] exp_pend;

    regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .FIXED_PRIORITY(0)) u_dut (
        .Clk(Clk), .Reset(Reset),
        .Req0Valid(Req0Valid), .Req0Reg(Req0Reg), .Req0Data(Req0Data), .Req0Ready(Req0Ready),
        .Req1Valid(Req1Valid), .Req1Reg(Req1Reg), .Req1Data(Req1Data), .Req1Ready(Req1Ready),
        .Reserve(Reserve), .ReserveReg(ReserveReg),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2), .Stall(Stall),
        .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
        .Pending(Pending)
    );

    regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .FIXED_PRIORITY(1)) u_fp (
        .Clk(Clk), .Reset(Reset),
        .Req0Valid(Req0Valid), .Req0Reg(Req0Reg), .Req0Data(Req0Data), .Req0Ready(fp_Req0Ready),
        .Req1Valid(Req1Valid), .Req1Reg(Req1Reg), .Req1Data(Req1Data), .Req1Ready(fp_Req1Ready),
        .Reserve(Reserve), .ReserveReg(ReserveReg),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2), .Stall(fp_Stall),
        .WriteRegister(fp_WriteRegister), .WriteData(fp_WriteData), .RegWrite(fp_RegWrite),
        .Pending(fp_Pending)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [4:0] r, input logic [31:0] d);
        wr_t e;
        e.r = r;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every presented write must match the oldest expected write
    always @(negedge Clk) begin
        if (RegWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {27'd0, WriteRegister, WriteData}, 64'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_reg",  {59'd0, WriteRegister}, {59'd0, e.r});
                check("write_data", {32'd0, WriteData},     {32'd0, e.d});
            end
        end
    end

    initial begin
        Reset = 1'b0;
        Req0Valid = 1'b1; Req0Reg = 5'd1; Req0Data = 32'hAA;
        Req1Valid = 1'b1; Req1Reg = 5'd2; Req1Data = 32'hBB;
        Reserve = 1'b0; ReserveReg = '0; ReadRegister1 = '0; ReadRegister2 = '0;
        #1;
        check("rst_ready0", {63'd0, Req0Ready}, 64'd0);
        check("rst_ready1", {63'd0, Req1Ready}, 64'd0);
        tick();
        tick();
        check("rst_ready0_b", {63'd0, Req0Ready}, 64'd0);
        check("rst_ready1_b", {63'd0, Req1Ready}, 64'd0);
        check("rst_regwrite", {63'd0, RegWrite}, 64'd0);
        check("rst_pending", {32'd0, Pending}, 64'd0);
        check("rst_stall", {63'd0, Stall}, 64'd0);
        check("rst_fp_pending", {32'd0, fp_Pending}, 64'd0);
        check("rst_fp_stall", {63'd0, fp_Stall}, 64'd0);

        // Round-robin conflict: R0 9/0A, R1 10/0B, new data after each accept
        Reset = 1'b1;
        Req0Reg = 5'd9;  Req0Data = 32'h0A;
        Req1Reg = 5'd10; Req1Data = 32'h0B;
        #1;
        check("rr1_ready0", {63'd0, Req0Ready}, 64'd1);
        check("rr1_ready1", {63'd0, Req1Ready}, 64'd0);
        check("fp1_ready0", {63'd0, fp_Req0Ready}, 64'd1);
        push(5'd9, 32'h0A);
        tick();
        check("fp_out_reg", {59'd0, fp_WriteRegister}, 64'd9);
        check("fp_out_data", {32'd0, fp_WriteData}, 64'h0A);
        check("fp_out_we", {63'd0, fp_RegWrite}, 64'd1);
        Req0Data = 32'h0C;
        #1;
        check("rr2_ready0", {63'd0, Req0Ready}, 64'd0);
        check("rr2_ready1", {63'd0, Req1Ready}, 64'd1);
        check("fp2_ready0", {63'd0, fp_Req0Ready}, 64'd1);
        check("fp2_ready1", {63'd0, fp_Req1Ready}, 64'd0);
        push(5'd10, 32'h0B);
        tick();
        Req1Data = 32'h0D;
        #1;
        check("rr3_ready0", {63'd0, Req0Ready}, 64'd1);
        check("rr3_ready1", {63'd0, Req1Ready}, 64'd0);
        check("fp3_ready0", {63'd0, fp_Req0Ready}, 64'd1);
        push(5'd9, 32'h0C);
        tick();
        Req0Data = 32'h0E;
        #1;
        check("rr4_ready0", {63'd0, Req0Ready}, 64'd0);
        check("rr4_ready1", {63'd0, Req1Ready}, 64'd1);
        check("fp4_ready0", {63'd0, fp_Req0Ready}, 64'd1);
        check("fp4_ready1", {63'd0, fp_Req1Ready}, 64'd0);
        push(5'd10, 32'h0D);
        tick();
        Req0Valid = 1'b0; Req1Valid = 1'b0;
        tick();

        // Single requester Req0: reg 8 = 0x11
        Req0Valid = 1'b1; Req0Reg = 5'd8; Req0Data = 32'h11;
        #1;
        check("single_ready0", {63'd0, Req0Ready}, 64'd1);
        check("single_ready1", {63'd0, Req1Ready}, 64'd0);
        push(5'd8, 32'h11);
        tick();
        Req0Valid = 1'b0;
        tick();
        check("single_idle_we", {63'd0, RegWrite}, 64'd0);
        check("single_hold_reg", {59'd0, WriteRegister}, 64'd8);
        check("single_hold_data", {32'd0, WriteData}, 64'h11);

        // Scoreboard: reserve 16, then Req1 writes 16 = 0x1234
        Reserve = 1'b1; ReserveReg = 5'd16;
        tick();
        Reserve = 1'b0; ReadRegister1 = 5'd16;
        #1;
        check("sb_stall_set", {63'd0, Stall}, 64'd1);
        check("sb_pend16_set", {63'd0, Pending[16]}, 64'd1);
        Req1Valid = 1'b1; Req1Reg = 5'd16; Req1Data = 32'h1234;
        #1;
        check("sb_ready1", {63'd0, Req1Ready}, 64'd1);
        check("sb_stall_pre_accept", {63'd0, Stall}, 64'd1);
        push(5'd16, 32'h1234);
        tick();
        Req1Valid = 1'b0;
        #1;
        check("sb_stall_clear", {63'd0, Stall}, 64'd0);
        check("sb_pend16_clear", {63'd0, Pending[16]}, 64'd0);
        check("sb_we_same_cycle", {63'd0, RegWrite}, 64'd1);
        check("sb_reg_same_cycle", {59'd0, WriteRegister}, 64'd16);
        tick();

        // Simultaneous set and clear of register 17
        ReadRegister1 = '0;
        Reserve = 1'b1; ReserveReg = 5'd17;
        tick();
        Req1Valid = 1'b1; Req1Reg = 5'd17; Req1Data = 32'h77;
        ReadRegister2 = 5'd17;
        #1;
        check("sc_ready1", {63'd0, Req1Ready}, 64'd1);
        push(5'd17, 32'h77);
        tick();
        Reserve = 1'b0; Req1Valid = 1'b0;
        #1;
        check("sc_pend17", {63'd0, Pending[17]}, 64'd1);
        check("sc_stall", {63'd0, Stall}, 64'd1);

        // Register 0: accepted but never written, never reserved
        Req0Valid = 1'b1; Req0Reg = 5'd0; Req0Data = 32'hFF;
        #1;
        check("r0_ready0", {63'd0, Req0Ready}, 64'd1);
        tick();
        Req0Valid = 1'b0;
        #1;
        check("r0_no_write", {63'd0, RegWrite}, 64'd0);
        Reserve = 1'b1; ReserveReg = 5'd0;
        tick();
        Reserve = 1'b0;
        exp_pend = '0;
        exp_pend[17] = 1'b1;
        check("r0_reserve_ignored", {32'd0, Pending}, {32'd0, exp_pend});

        // Mid-operation reset with pending 17/20 and a just-accepted write
        Reserve = 1'b1; ReserveReg = 5'd20;
        tick();
        Reserve = 1'b0;
        exp_pend[20] = 1'b1;
        check("mid_pend_before", {32'd0, Pending}, {32'd0, exp_pend});
        Req0Valid = 1'b1; Req0Reg = 5'd5; Req0Data = 32'h55;
        push(5'd5, 32'h55);
        tick();
        Req1Valid = 1'b1; Req1Reg = 5'd6; Req1Data = 32'h66;
        Reset = 1'b0;
        #1;
        check("mid_rst_ready0", {63'd0, Req0Ready}, 64'd0);
        check("mid_rst_ready1", {63'd0, Req1Ready}, 64'd0);
        tick();
        check("mid_rst_we", {63'd0, RegWrite}, 64'd0);
        check("mid_rst_pending", {32'd0, Pending}, 64'd0);
        check("mid_rst_stall", {63'd0, Stall}, 64'd0);
        Reset = 1'b1; Req0Valid = 1'b0; Req1Valid = 1'b0;
        tick();
        tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
